// File: rtl/dm_pkg.sv
// Shared encodings and byte-lane helpers for the data-memory controller.
package dm_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 4'b0001 << lo;
      SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Sub-word data is replicated across lanes so the lane mask alone picks the target bytes.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic is_unsigned);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return is_unsigned ? {24'h0, b} : 32'(b);
      SZ_H:    return is_unsigned ? {16'h0, h} : 32'(h);
      SZ_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dm_ram_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
module dm_ram_be #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: power-on clear, byte-lane stores, extended sub-word loads,
// misalignment reporting.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk_dm,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        Mem_Write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] DM_Addr,
  input  logic [31:0] M_W_Data,
  output logic        ready,
  output logic [31:0] M_R_Data,
  output logic        rd_valid,
  output logic        misalign,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 2**ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              acc;
  logic              fault;
  logic              ram_re;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic              vld_p1;
  logic              mis_p1;
  logic              ld_ok_p1;
  logic [1:0]        size_p1;
  logic [1:0]        lo_p1;
  logic              uns_p1;

  assign acc   = req_valid && ready;
  assign fault = is_fault(req_size, DM_Addr[1:0]);

  always_comb begin
    ram_re    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = DM_Addr[ADDR_W+1:2];
    ram_wdata = store_align(req_size, M_W_Data);
    if (state == INIT) begin
      ram_we    = 4'b1111;
      ram_addr  = cnt;
      ram_wdata = 32'h0;
    end else if (acc && !fault) begin
      if (Mem_Write) ram_we = lane_mask(req_size, DM_Addr[1:0]);
      else           ram_re = 1'b1;
    end
  end

  dm_ram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk_dm),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage p0 -> p1: control and status
  always_ff @(posedge clk_dm or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_ZERO ? INIT : RUN;
      cnt      <= '0;
      ready    <= 1'b0;
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      ld_ok_p1 <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      vld_p1 <= 1'b0;
      mis_p1 <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          if (acc) begin
            if (fault) begin
              mis_p1   <= 1'b1;
              err_addr <= DM_Addr;
            end
            if (!Mem_Write) begin
              vld_p1   <= 1'b1;
              ld_ok_p1 <= !fault;
            end
          end
        end
      endcase
    end
  end

  // Stage p0 -> p1: load formatting info, aligned with the RAM read
  always_ff @(posedge clk_dm) begin
    if (acc && !Mem_Write) begin
      size_p1 <= req_size;
      lo_p1   <= DM_Addr[1:0];
      uns_p1  <= req_unsigned;
    end
  end

  assign rd_valid = vld_p1;
  assign misalign = mis_p1;
  assign M_R_Data = ld_ok_p1 ? load_extract(ram_rdata, size_p1, lo_p1, uns_p1) : 32'h0;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed and randomized bench for dm_ctrl against a byte-array memory model.
module tb_dm_ctrl;

  logic        clk_dm = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        Mem_Write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] DM_Addr;
  logic [31:0] M_W_Data;
  logic        ready;
  logic [31:0] M_R_Data;
  logic        rd_valid;
  logic        misalign;
  logic [31:0] err_addr;

  always #5 clk_dm = ~clk_dm;

  dm_ctrl #(.ADDR_W(6), .INIT_ZERO(1'b1)) dut (
    .clk_dm       (clk_dm),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .Mem_Write    (Mem_Write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .DM_Addr      (DM_Addr),
    .M_W_Data     (M_W_Data),
    .ready        (ready),
    .M_R_Data     (M_R_Data),
    .rd_valid     (rd_valid),
    .misalign     (misalign),
    .err_addr     (err_addr)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: 64 words = 256 bytes, byte address taken modulo 256.
  byte unsigned mdl [256];
  logic [31:0]  mdl_rd;
  logic [31:0]  mdl_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic mdl_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    longint v = 0;
    int     n = nbytes(sz);
    int     base = int'(a % 256);
    for (int k = 0; k < n; k++) v += longint'(mdl[(base + k) % 256]) << (8 * k);
    if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int base = int'(a % 256);
    for (int k = 0; k < nbytes(sz); k++) mdl[(base + k) % 256] = byte'(d >> (8 * k));
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mdl_rd  = 32'h0;
    mdl_err = 32'h0;
  endtask

  task automatic op(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d);
    logic f;
    f = mdl_fault(sz, a);
    if (f) begin
      mdl_err = a;
      if (!wr) mdl_rd = 32'h0;
    end else if (wr) begin
      mdl_store(sz, a, d);
    end else begin
      mdl_rd = mdl_load(sz, uns, a);
    end
    req_valid = 1'b1; Mem_Write = wr; req_size = sz; req_unsigned = uns;
    DM_Addr = a; M_W_Data = d;
    @(posedge clk_dm); #1;
    req_valid = 1'b0;
    chk({tag, ".misalign"}, 32'(misalign), 32'(f));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(!wr));
    chk({tag, ".rdata"},    M_R_Data, mdl_rd);
    chk({tag, ".err_addr"}, err_addr, mdl_err);
    chk({tag, ".ready"},    32'(ready), 32'h1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk_dm); #1;
    chk("idle.rd_valid", 32'(rd_valid), 32'h0);
    chk("idle.misalign", 32'(misalign), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"},    32'(ready), 32'h0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, ".misalign"}, 32'(misalign), 32'h0);
    chk({tag, ".err_addr"}, err_addr, 32'h0);
    chk({tag, ".rdata"},    M_R_Data, 32'h0);
  endtask

  // Counts edges after reset release; requests during the clear must be ignored.
  task automatic init_seq();
    for (int k = 0; k <= 64; k++) begin
      chk($sformatf("init.ready@%0d", k), 32'(ready), 32'(k == 64));
      chk("init.rd_valid", 32'(rd_valid), 32'h0);
      chk("init.misalign", 32'(misalign), 32'h0);
      if (k < 64) begin
        req_valid = 1'b1; Mem_Write = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'b0;
        DM_Addr = 32'($urandom_range(0, 255)); M_W_Data = $urandom;
        @(posedge clk_dm); #1;
      end
    end
    req_valid = 1'b0;
    mdl_clear();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; Mem_Write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; DM_Addr = 32'h0; M_W_Data = 32'h0;
    mdl_clear();
    repeat (2) @(posedge clk_dm);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    init_seq();

    op("lw_3c", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
    chk("lw_3c.const", M_R_Data, 32'h0);

    op("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    op("sb_11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
    op("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw_10.const", M_R_Data, 32'h1122AA44);
    op("lh_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("lh_12.const", M_R_Data, 32'h00001122);
    op("lb_11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    chk("lb_11.const", M_R_Data, 32'hFFFFFFAA);
    op("lbu_11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    chk("lbu_11.const", M_R_Data, 32'h000000AA);

    op("sh_22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001);
    op("lh_22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    chk("lh_22.const", M_R_Data, 32'hFFFF8001);
    op("lhu_22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    chk("lhu_22.const", M_R_Data, 32'h00008001);
    idle();
    chk("hold.rdata", M_R_Data, 32'h00008001);

    op("sw_0", 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D);
    op("lw_05", 1'b0, 2'd2, 1'b0, 32'h05, 32'h0);
    chk("lw_05.err", err_addr, 32'h05);
    op("sh_03", 1'b1, 2'd1, 1'b0, 32'h03, 32'h0000BEEF);
    op("bad_ld", 1'b0, 2'd3, 1'b0, 32'h08, 32'h0);
    op("bad_st", 1'b1, 2'd3, 1'b0, 32'h0C, 32'h12345678);
    op("lw_0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("lw_0.const", M_R_Data, 32'hCAFEF00D);

    op("sw_100", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    op("lw_000", 1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
    chk("alias.const", M_R_Data, 32'hDEADBEEF);

    for (int i = 0; i < 400; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom & 32'h3FF;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 4) == 0) idle();
      else op("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    op("pre_sw", 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
    op("pre_bad", 1'b1, 2'd1, 1'b0, 32'h41, 32'h0);
    op("pre_lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_run");
    repeat (2) @(posedge clk_dm);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk_dm);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_init");
    repeat (2) @(posedge clk_dm);
    #1 rst_n = 1'b1;
    init_seq();

    op("clr_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    op("clr_40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    op("clr_00", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    chk("clr_00.const", M_R_Data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
Parametrised data-memory controller for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 64-word, word-only data RAM. It adds configurable depth, RISC-style sub-word stores with byte lanes, sign/zero-extended sub-word loads, and misalignment detection. It also runs a power-on clear sequence that zeroes the array after every reset. It sits between the ALU address output and the write-back mux.

Parameters:
ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words of 32 bits
INIT_ZERO, 1, 1 = clear every word after reset before accepting requests; 0 = skip the clear (array contents undefined)

Ports:
clk_dm  input  1  memory clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request strobe for this cycle
Mem_Write  input  1  1 = store, 0 = load (sampled with req_valid)
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
DM_Addr  input  32  byte address
M_W_Data  input  32  store data; sub-word data taken from the LSBs
ready  output  1  1 = requests are accepted
M_R_Data  output  32  load result, registered
rd_valid  output  1  one-cycle pulse when M_R_Data is updated by a load
misalign  output  1  one-cycle pulse for a faulting request
err_addr  output  32  DM_Addr of the most recent faulting request

Behaviour:
- Reset: all outputs 0; init counter 0.
  - State goes to INIT if INIT_ZERO=1, else RUN.
  - The array is not reset directly.
- States: INIT -> RUN only.
  - INIT: each cycle writes 0 to mem[cnt] and increments cnt.
  - After the write of cnt = DEPTH-1, go to RUN on the next edge. INIT lasts exactly DEPTH cycles.
  - ready = (state == RUN), registered.
  - Requests in INIT are ignored: no write, no rd_valid, no misalign.
- Reset asserted mid-INIT or mid-RUN: return to the reset state immediately. The clear sequence restarts from word 0.
- Accept: req_valid && ready. One request per cycle; no back-pressure in RUN.
- Word index: DM_Addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias modulo DEPTH*4.
- Fault conditions:
  - size 11;
  - half with DM_Addr[0] = 1;
  - word with DM_Addr[1:0] != 0.
- On a fault:
  - no array write;
  - misalign pulses 1 the cycle after accept;
  - err_addr updates on the same edge;
  - for a load, rd_valid pulses with M_R_Data = 0.
- Stores: byte lanes are selected by DM_Addr[1:0].
  - Byte: lane = addr[1:0], data M_W_Data[7:0].
  - Half: lanes {addr[1],0}..+1, data M_W_Data[15:0], little-endian.
  - Word: all lanes.
  - Unselected lanes keep their old value.
  - The write takes effect at the accepting edge.
- Loads: synchronous read, latency 1.
  - rd_valid = 1 in the cycle after accept.
  - The selected byte/half is right-aligned and extended per req_unsigned. Word loads ignore req_unsigned.
  - M_R_Data holds its value until the next load completes. Stores do not change it.
- Store at cycle N followed by a load of the same word at cycle N+1 returns the updated data.
- Back-to-back loads give rd_valid high on consecutive cycles.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_B / SZ_H / SZ_W / SZ_BAD;
  - state enum INIT / RUN;
  - function lane_mask(size, addr[1:0]) returning 4 bits;
  - function load_extract(word, size, addr[1:0], unsigned).
- One sub-module, dm_ram_be: a DEPTH x 32 single-port RAM with 4-bit byte-write enable and registered read. It maps to block RAM.

Test Plan:
- Reset, then hold 64 cycles with ADDR_W = 6 -> ready = 0 for cycles 0..63 and 1 at cycle 64. A word load of address 0x3C then returns 0x00000000.
- sw 0x11223344 at 0x10; sb 0xAA at 0x11; load word at 0x10 -> 0x1122AA44. lh 0x12 signed -> 0x00001122. lb 0x11 signed -> 0xFFFFFFAA. lbu 0x11 -> 0x000000AA.
- sh 0x8001 at 0x22, then lh at 0x22 on the next cycle -> rd_valid at +1 with 0xFFFF8001. lhu at 0x22 -> 0x00008001.
- Misaligned cases:
  - lw at 0x05 -> misalign pulse, err_addr = 0x05, rd_valid with data 0.
  - sh at 0x03 -> misalign pulse; word 0 unchanged.
  - size 11 -> misalign pulse.
- Aliasing: sw 0xDEADBEEF at 0x100 (ADDR_W = 6) -> load word at 0x000 returns 0xDEADBEEF.
- Assert rst_n low at INIT cycle 20 -> outputs 0 immediately. After release, ready rises after the full DEPTH cycles.
